// File: rtl/glyph_fetch_sequencer.sv
// Glyph ROM fetch sequencer: per-cell code/row fetch, MSB-first pixel serialiser, host reads in idle ROM slots.
// Define GLYPH_CURSOR_EN to add cursor_on/cursor_col and invert the pixels of the cursor cell.
module glyph_fetch_sequencer #(
  parameter int CODE_W = 2,
  parameter int ROW_W  = 4,
  parameter int COLS   = 80,
  parameter int COL_W  = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     line_start,
  input  logic [ROW_W-1:0]         row,
  output logic                     char_req,
  output logic [COL_W-1:0]         char_col,
  input  logic [CODE_W-1:0]        char_code,
  output logic [CODE_W+ROW_W-1:0]  rom_addr,
  input  logic [7:0]               rom_data,
  input  logic                     host_req,
  input  logic [CODE_W+ROW_W-1:0]  host_addr,
  output logic                     host_ack,
  output logic [7:0]               host_data,
`ifdef GLYPH_CURSOR_EN
  input  logic                     cursor_on,
  input  logic [COL_W-1:0]         cursor_col,
`endif
  output logic                     pixel_valid,
  output logic                     pixel_bit
);

  localparam int FCOL_W = COL_W + 1;
  localparam int PIX_W  = COL_W + 3;
  localparam logic [FCOL_W-1:0] COLS_F   = FCOL_W'(COLS);
  localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(COLS * 8 - 1);

  // state    | meaning
  // IDLE     | no display activity, every ROM slot belongs to the host
  // PREFETCH | first 8 cycles after line_start, cell 0 being fetched
  // ACTIVE   | pixels streaming, one cell fetched ahead per 8-cycle group
  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_ACTIVE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_phase;
  logic [FCOL_W-1:0] r_fcol;
  logic [CODE_W-1:0] r_code;
  logic [7:0]        r_next_byte;
  logic [7:0]        r_shift;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic              r_host_ack;
  logic [7:0]        r_host_data;

  logic w_busy;
  logic w_fetch_col;
  logic w_disp_req;
  logic w_disp_rom;
  logic w_load;
  logic w_free;
  logic w_grant;
  logic w_cursor_hit;

  assign w_busy      = (r_state != S_IDLE);
  assign w_fetch_col = (r_fcol < COLS_F);
  assign w_disp_req  = w_busy && (r_phase == 3'd0) && w_fetch_col;
  assign w_disp_rom  = w_busy && (r_phase == 3'd1) && w_fetch_col;
  assign w_load      = w_busy && (r_phase == 3'd7);

  // Phase 7 is held back from the host even after the last cell so the slot pattern stays fixed.
  assign w_free  = !w_busy
                || ((r_phase >= 3'd2) && (r_phase <= 3'd6))
                || ((r_phase <= 3'd1) && !w_fetch_col);
  assign w_grant = w_free && host_req && !r_host_ack && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (line_start) begin
      w_state_nxt = S_PREFETCH;
    end else begin
      case (r_state)
        S_PREFETCH: if (r_phase == 3'd7) w_state_nxt = S_ACTIVE;
        S_ACTIVE:   if (r_pix_cnt == '0) w_state_nxt = S_IDLE;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    char_req = w_disp_req;
    char_col = w_disp_req ? r_fcol[COL_W-1:0] : '0;
    if (w_disp_rom) begin
      rom_addr = {r_code, row};
    end else if (w_grant) begin
      rom_addr = host_addr;
    end else begin
      rom_addr = '0;
    end
    pixel_valid = (r_state == S_ACTIVE);
    pixel_bit   = pixel_valid && (r_shift[7] ^ w_cursor_hit);
  end

  assign host_ack  = r_host_ack;
  assign host_data = r_host_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase     <= '0;
      r_fcol      <= '0;
      r_code      <= '0;
      r_next_byte <= '0;
      r_shift     <= '0;
      r_pix_cnt   <= '0;
    end else if (line_start) begin
      r_phase <= '0;
      r_fcol  <= '0;
      r_shift <= '0;
    end else if (w_busy) begin
      r_phase <= r_phase + 3'd1;
      if (w_disp_req) begin
        r_code <= char_code;
      end
      if (w_disp_rom) begin
        r_next_byte <= rom_data;
        r_fcol      <= r_fcol + FCOL_W'(1);
      end
      if (w_load) begin
        r_shift <= r_next_byte;
      end else begin
        r_shift <= {r_shift[6:0], 1'b0};
      end
      // Pixel window down-counter: parked at the last index until ACTIVE starts.
      if (r_state == S_PREFETCH) begin
        r_pix_cnt <= PIX_LAST;
      end else if (r_pix_cnt != '0) begin
        r_pix_cnt <= r_pix_cnt - PIX_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_host_ack  <= 1'b0;
      r_host_data <= '0;
    end else begin
      r_host_ack <= w_grant;
      if (w_grant) begin
        r_host_data <= rom_data;
      end
    end
  end

`ifdef GLYPH_CURSOR_EN
  logic [COL_W-1:0] r_disp_col;

  // fcol has already advanced past the cell being loaded, hence the -1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_disp_col <= '0;
    end else if (!line_start && w_load) begin
      r_disp_col <= COL_W'(r_fcol - FCOL_W'(1));
    end
  end

  assign w_cursor_hit = cursor_on && (r_disp_col == cursor_col);
`else
  assign w_cursor_hit = 1'b0;
`endif

endmodule

// File: doc/glyph_fetch_sequencer.md
Name: glyph_fetch_sequencer

Overview:
- Sequences character-glyph ROM fetches for one text scanline: requests the character code for each cell, reads the glyph row byte, and serialises it MSB-first as pixel bits.
- Arbitrates the same ROM port with a host read requester, which is served in ROM slots the display does not use.
- Sits between the text buffer/timing generator and the combinational character ROM, on the pixel clock.

Parameters:
- CODE_W, 2, character code width (ROM high address bits)
- ROW_W, 4, glyph row index width (ROM low address bits)
- COLS, 80, text cells per scanline
- COL_W, 7, cell index width; must satisfy 2^COL_W >= COLS

Ports:
- clock  in  1  pixel clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- line_start  in  1  one-cycle pulse that starts a scanline fetch
- row  in  ROW_W  glyph row for this scanline; held stable for the whole line
- char_req  out  1  high for one cycle when char_col is valid
- char_col  out  COL_W  cell index being requested
- char_code  in  CODE_W  character for char_col, combinational, same cycle as char_req
- rom_addr  out  CODE_W+ROW_W  ROM address
- rom_data  in  8  ROM byte, combinational from rom_addr
- host_req  in  1  host read request; held until host_ack
- host_addr  in  CODE_W+ROW_W  host read address
- host_ack  out  1  one-cycle pulse; host_data valid in that cycle
- host_data  out  8  byte read for the host
- pixel_valid  out  1  high while pixel_bit carries active pixels
- pixel_bit  out  1  serialised glyph pixel

Behaviour:
- Reset: all outputs are 0. State goes to IDLE and all counters clear.
- States:
  - IDLE: no display activity.
  - PREFETCH: first 8 cycles after line_start.
  - ACTIVE: pixels streaming.
- line_start sampled high, from any state: state goes to PREFETCH, phase=0, fetch column fcol=0, shift register cleared. If this happens mid-line, the current line is aborted and pixel_valid drops on the next cycle.
- phase is a 3-bit counter that increments every cycle outside IDLE and wraps 7 to 0.
- Display fetch happens only while fcol < COLS:
  - Phase 0: char_req=1, char_col=fcol, and char_code is captured into code_r at the end of the cycle.
  - Phase 1: rom_addr={code_r,row}. rom_data is captured into next_byte at the end of the cycle, and fcol increments.
- Phase 7 end: shift_reg <= next_byte. PREFETCH moves to ACTIVE.
- ACTIVE:
  - pixel_bit=shift_reg[7]; shift left by 1 each cycle, except on the load cycle.
  - pixel_valid=1 for exactly COLS*8 cycles, then state returns to IDLE.
  - If line_start was sampled at edge E0, the first pixel is valid in the cycle after edge E8.
- pixel_bit=0 whenever pixel_valid=0.
- Host slot: a cycle is free if any of the following holds:
  - state is IDLE;
  - phase is in 2..6;
  - phase is 0 or 1 and fcol >= COLS.
- Host arbitration:
  - A free cycle with host_req=1 and host_ack=0 grants the host: rom_addr=host_addr.
  - rom_data is registered into host_data and host_ack pulses in the next cycle.
  - Host requests never delay or alter display fetches; the display always wins phases 0 and 1.
- Worst-case host latency is 3 cycles from host_req to grant (request arriving at phase 7).
- The host must drop host_req in the ack cycle. No grant is issued in a cycle where host_ack=1.
- rom_addr=0 when neither display nor host owns the slot.
- host_data holds its last value between acks.

Optional Feature:
- Macro GLYPH_CURSOR_EN.
- Defined:
  - Adds inputs cursor_on (1 bit) and cursor_col (COL_W bits).
  - A register disp_col tracks the cell currently shifting out; it is loaded with fcol-1 at each phase-7 load.
  - pixel_bit is inverted while pixel_valid=1, cursor_on=1 and disp_col==cursor_col.
- Undefined: those ports do not exist and pixel_bit is the plain glyph bit.

Test Plan:
- COLS=4, row=5, char_code=col+1, ROM model returns {addr,2'b01}:
  - Pulse line_start.
  - char_req must pulse at cycles 1, 9, 17 and 25 after the pulse.
  - pixel_valid must be high for 32 cycles starting 9 cycles after the pulse.
  - pixel stream must equal the bytes 0x55,0x95,0xD5,0x15, MSB first.
- Reset asserted mid-ACTIVE: all outputs must go to 0 immediately, with no char_req and no host_ack until the next line_start.
- Host read of addr 0x2A while IDLE: host_ack must come 1 cycle after grant with host_data=0xA9.
- Host request held high during ACTIVE:
  - Grants must occur only in phases 2..6.
  - Display bytes must be unchanged.
  - Back-to-back requests must be acked at most every 2 cycles.
- line_start re-pulsed at pixel 13: pixel_valid must fall next cycle and the line must restart at cell 0, after which exactly 32 valid pixels follow.
- GLYPH_CURSOR_EN defined, cursor_on=1, cursor_col=2: only pixels 16..23 must be inverted, giving 0x2A in place of 0xD5.
